sdiv_seq_ctrl: RTL

Multi-cycle signed divider. It runs one non-restoring add/subtract step per clock on a shared WIDTH-bit adder, then applies a final remainder-correction step and a sign-fix step. It sits in the ALU signed-arithmetic group and replaces the unrolled array divider where area matters. It talks to the ALU issue logic through a start/busy/done handshake.

---
 rtl/alu_div_pkg.sv | 17 +
 rtl/sdiv_nr_step.sv | 17 +
 rtl/sdiv_seq_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_div_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding
// and the fixed quotient pattern reported on a zero divisor.
package alu_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ITER,
    CORRECT,
    FIX,
    DONE
  } div_state_e;

  localparam int DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/sdiv_nr_step.sv
// One non-restoring step: adds or subtracts the zero-extended divisor
// magnitude from the (WIDTH+1)-bit signed partial remainder.
module sdiv_nr_step #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH:0]   a_i,
  input  logic        [WIDTH-1:0] d_i,
  input  logic                    sub_i,
  output logic signed [WIDTH:0]   sum_o
);

  logic signed [WIDTH:0] d_ext;

  assign d_ext = signed'({1'b0, d_i});
  assign sum_o = sub_i ? (a_i - d_ext) : (a_i + d_ext);

endmodule

// File: rtl/sdiv_seq_ctrl.sv
// Multi-cycle signed divider: one non-restoring step per clock on a shared
// adder, followed by a remainder-correction cycle and a sign-fix cycle.
module sdiv_seq_ctrl
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      quotient_q, quotient_d;
  logic [WIDTH-1:0]      remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;

  logic signed [WIDTH:0] p_q, p_d;
  logic [WIDTH-1:0]      q_q, q_d;
  logic [WIDTH-1:0]      dabs_q, dabs_d;
  logic                  sgnq_q, sgnq_d;
  logic                  sgnr_q, sgnr_d;

  logic signed [WIDTH:0] step_a;
  logic signed [WIDTH:0] step_sum;
  logic                  step_sub;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  // MIN_INT maps to 2^(WIDTH-1), which is exact when read as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? neg(x) : x;
  endfunction

  // CORRECT reuses the step adder with the add forced on the unshifted P.
  assign step_a   = (state_q == CORRECT) ? p_q : {p_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign step_sub = (state_q == ITER) && !p_q[WIDTH];

  sdiv_nr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a_i   (step_a),
    .d_i   (dabs_q),
    .sub_i (step_sub),
    .sum_o (step_sum)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    p_d         = p_q;
    q_d         = q_q;
    dabs_d      = dabs_q;
    sgnq_d      = sgnq_q;
    sgnr_d      = sgnr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dabs_d = mag(divisor);
          q_d    = mag(dividend);
          sgnq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sgnr_d = dividend[WIDTH-1];
          p_d    = '0;
          cnt_d  = '0;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = {WIDTH{DBZ_QUOTIENT[0]}};
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
        p_d   = step_sum;
        q_d   = {q_q[WIDTH-2:0], ~step_sum[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = CORRECT;
        end
      end
      CORRECT: begin
        if (p_q[WIDTH]) begin
          p_d = step_sum;
        end
        state_d = FIX;
      end
      FIX: begin
        quotient_d  = sgnq_q ? neg(q_q) : q_q;
        remainder_d = sgnr_q ? neg(p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
        dbz_d       = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Working datapath needs no reset: it is fully reloaded on every accept.
  always_ff @(posedge clk) begin
    p_q    <= p_d;
    q_q    <= q_d;
    dabs_q <= dabs_d;
    sgnq_q <= sgnq_d;
    sgnr_q <= sgnr_d;
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
